hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Next-generation pipeline hazard unit. It keeps a shadow scoreboard of in-flight
//  instructions (EX..WB) and generates load-use stalls, branch bubbles, and
//  multi-cycle-op freezes. It also drives per-operand forwarding selects for EX.
//  Sits beside the decode/EX boundary and replaces the fixed two-stage flush-only
//  hazard logic.
//  Generalised in depth, load latency and multi-cycle latency.
// PARAMETERS
//  REG_W     5  register-index width
//  DEPTH     3  tracked slots: 0=EX, 1=MEM, 2=WB, ...; legal range DEPTH>=2
//  LOAD_SLOT 2  first slot whose load data is forwardable; legal range 1..DEPTH-1
//  MC_LAT    4  EX occupancy in cycles of a multi-cycle op; legal range >=1
// PORTS
//  CLK          in  1      clock, rising edge
//  RST          in  1      synchronous, active-high reset
//  dec_valid    in  1      decode holds a real instruction
//  dec_rs/rt    in  REG_W  decode source registers
//  dec_rs_used  in  1      rs is actually read (one flag per source: rs_used, rt_used)
//  dec_wen      in  1      decode instruction writes the register file
//  dec_dest     in  REG_W  decode destination register
//  dec_load     in  1      decode instruction is a load
//  dec_mc       in  1      decode instruction is multi-cycle (mult/div)
//  ex_br_flush  in  1      taken branch/jump resolved in EX; kill decode
//  fetch_stall  out 1      hold PC, IF/ID and decode
//  dx_flush     out 1      inject bubble into ID/EX
//  ex_hold      out 1      hold ID/EX; bubble into EX/MEM
//  fwd_a/fwd_b  out FW     FW=$clog2(DEPTH); 0=regfile, k=forward from slot k
//  mc_busy      out 1      multi-cycle op still occupying EX
// BEHAVIOUR
//  - Slot record: valid, wen, load, dest, rs, rt, rs_used, rt_used. Slots shift 0->DEPTH-1.
//  - Reset: all slots invalid, mc counter=0, every output 0. Reset mid-mc aborts it.
//  - lu_hit: dec_valid and a used src!=0 matches dest of slot j with
//    j<=LOAD_SLOT-2, where slot j is valid, wen and load.
//  - mc_busy = (mc_cnt!=0). The counter is registered.
//  - Priority each cycle: ex_br_flush > mc_busy > lu_hit > advance.
//    * flush: dx_flush=1, fetch_stall=0; slot0<-bubble; others shift. lu_hit ignored.
//    * mc_busy: fetch_stall=1, ex_hold=1, dx_flush=0; slot0 holds; slot1<-bubble;
//      slots>=2 shift; mc_cnt--.
//    * lu_hit: fetch_stall=1, dx_flush=1; slot0<-bubble; others shift.
//    * advance: slot0<-decode, with valid=dec_valid; others shift.
//      If dec_valid&dec_mc, mc_cnt<=MC_LAT-1.
//  - ex_br_flush while mc_busy is illegal. The assertion fires and the flush is ignored.
//  - Forwarding (combinational from slots): fwd_a = smallest k in 1..DEPTH-1 with
//    slot[k] valid, wen, dest==slot0.rs, dest!=0 and slot0.rs_used; else 0.
//    fwd_b is the same using rt.
//    Loads in slot k<LOAD_SLOT are never selected; the stall guarantees no such match.
//  - Slot0 invalid or src==r0 gives fwd=0. Writes to r0 never stall or forward.
//  - Slots beyond DEPTH-1 are covered by regfile write-before-read.
//  - An mc op captures its operands on its first EX cycle; fwd is only meaningful then.
//  - Stall/flush outputs are combinational from state plus dec_*; latency 0.
//    Scoreboard update latency is 1.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs lu_stall_cnt[31:0] and mc_stall_cnt[31:0].
//    Each is a saturating counter, incremented on cycles whose winning action is
//    lu_hit or mc_busy respectively. Both are cleared by RST.
//  Undefined: those ports and the counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  hazard_pkg: hz_slot_t struct, fwd_sel_t, HZ_ACT_* action enum
//    (ADVANCE/FLUSH/MC/LU), function is_r0().
//  Sub-module hazard_slot_pipe: the slot shift register, with per-slot
//  load/hold/bubble controls.
//  The top level holds the compare, priority and mc counter.
// TESTING
//  1 Reset: RST=1 for 2 cycles with dec_valid=1, dec_load=1 -> all outputs 0,
//    no slot captured.
//  2 ALU back-to-back: add r3 then sub r4,r3,r3 -> no stall; next cycle
//    fwd_a=fwd_b=1.
//  3 Load-use: lw r5 then add r6,r5,r1 -> one cycle of fetch_stall=1 and
//    dx_flush=1; two cycles later fwd_a=2.
//  4 r0: addi r0 then lw r0 then add r1,r0,r0 -> no stall, fwd_a=fwd_b=0.
//  5 Multi-cycle, MC_LAT=4: mult issued -> mc_busy=ex_hold=fetch_stall=1 for
//    3 cycles, slot1 bubbles, then advance.
//  6 ex_br_flush and lu_hit in the same cycle -> dx_flush=1, fetch_stall=0.
//    With HAZARD_STATS_EN, lu_stall_cnt is unchanged.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard scoreboard: slot record, forward select,
// per-cycle action encoding and the r0 helper.
package hazard_pkg;

    localparam int HZ_REG_W = 5;
    localparam int HZ_DEPTH = 3;
    localparam int HZ_FW    = $clog2(HZ_DEPTH);

    typedef logic [HZ_REG_W-1:0] reg_idx_t;
    typedef logic [HZ_FW-1:0]    fwd_sel_t;

    typedef struct packed {
        logic     valid;
        logic     wen;
        logic     load;
        reg_idx_t dest;
        reg_idx_t rs;
        reg_idx_t rt;
        logic     rs_used;
        logic     rt_used;
    } hz_slot_t;

    typedef enum logic [1:0] {
        HZ_ACT_ADVANCE,
        HZ_ACT_FLUSH,
        HZ_ACT_MC,
        HZ_ACT_LU
    } hz_act_e;

    function automatic logic is_r0(input reg_idx_t r);
        return r == '0;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side request and hazard-unit response bundle between ID/EX control and
// the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int DEPTH = hazard_pkg::HZ_DEPTH
);
    import hazard_pkg::*;

    localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          dec_valid;
    reg_idx_t      dec_rs;
    reg_idx_t      dec_rt;
    logic          dec_rs_used;
    logic          dec_rt_used;
    logic          dec_wen;
    reg_idx_t      dec_dest;
    logic          dec_load;
    logic          dec_mc;
    logic          ex_br_flush;

    logic          fetch_stall;
    logic          dx_flush;
    logic          ex_hold;
    logic [FW-1:0] fwd_a;
    logic [FW-1:0] fwd_b;
    logic          mc_busy;

    modport master (
        output dec_valid, dec_rs, dec_rt, dec_rs_used, dec_rt_used,
               dec_wen, dec_dest, dec_load, dec_mc, ex_br_flush,
        input  fetch_stall, dx_flush, ex_hold, fwd_a, fwd_b, mc_busy
    );

    modport slave (
        input  dec_valid, dec_rs, dec_rt, dec_rs_used, dec_rt_used,
               dec_wen, dec_dest, dec_load, dec_mc, ex_br_flush,
        output fetch_stall, dx_flush, ex_hold, fwd_a, fwd_b, mc_busy
    );

endinterface

// File: rtl/hazard_slot_pipe.sv
// Shift register of in-flight instruction records, slot 0 = EX onward, with
// hold/bubble controls for the two youngest slots.
module hazard_slot_pipe
    import hazard_pkg::*;
#(
    parameter int DEPTH = HZ_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  hz_slot_t              slot_i,
    input  logic                  hold0_i,
    input  logic                  bubble0_i,
    input  logic                  bubble1_i,
    output hz_slot_t [DEPTH-1:0]  slots_o
);

    hz_slot_t [DEPTH-1:0] slot_q;
    hz_slot_t [DEPTH-1:0] slot_d;

    always_comb begin
        // NOTE: assign the whole next-state vector first so no path leaves a
        // bit unassigned; otherwise always_comb infers a latch.
        slot_d = slot_q;
        if (hold0_i) begin
            slot_d[0] = slot_q[0];
        end else if (bubble0_i) begin
            slot_d[0] = '0;
        end else begin
            slot_d[0] = slot_i;
        end
        slot_d[1] = bubble1_i ? '0 : slot_q[0];
        for (int k = 2; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every slot samples
    // its neighbour's old value; blocking here would collapse the shift chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slots_o = slot_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: load-use stalls, branch bubbles, multi-cycle freezes and
// EX forwarding selects. Define HAZARD_STATS_EN to add stall statistics counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH     = HZ_DEPTH,
    parameter int LOAD_SLOT = 2,
    parameter int MC_LAT    = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hazard_scoreboard_if.slave  hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         lu_stall_cnt_o,
    output logic [31:0]         mc_stall_cnt_o
`endif
);

    localparam int FW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MCW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    hz_slot_t [DEPTH-1:0] slot_q;
    hz_slot_t             dec_slot;
    hz_act_e              act;
    logic                 lu_hit;
    logic                 mc_busy;
    logic [MCW-1:0]       mc_cnt_q;
    logic [MCW-1:0]       mc_cnt_d;
    logic [FW-1:0]        fwd_a;
    logic [FW-1:0]        fwd_b;

    assign dec_slot = '{valid:   hz.dec_valid,   wen:     hz.dec_wen,
                        load:    hz.dec_load,    dest:    hz.dec_dest,
                        rs:      hz.dec_rs,      rt:      hz.dec_rt,
                        rs_used: hz.dec_rs_used, rt_used: hz.dec_rt_used};

    assign mc_busy = (mc_cnt_q != '0);

    // Loads younger than LOAD_SLOT cannot feed decode yet; stall on a match.
    always_comb begin
        lu_hit = 1'b0;
        for (int j = 0; j <= LOAD_SLOT - 2; j++) begin
            if (slot_q[j].valid && slot_q[j].wen && slot_q[j].load && !is_r0(slot_q[j].dest)) begin
                if (hz.dec_rs_used && hz.dec_rs == slot_q[j].dest) lu_hit = 1'b1;
                if (hz.dec_rt_used && hz.dec_rt == slot_q[j].dest) lu_hit = 1'b1;
            end
        end
        lu_hit = lu_hit && hz.dec_valid;
    end

    // A flush during a multi-cycle op is illegal and loses to the freeze.
    always_comb begin
        if (hz.ex_br_flush && !mc_busy) act = HZ_ACT_FLUSH;
        else if (mc_busy)               act = HZ_ACT_MC;
        else if (lu_hit)                act = HZ_ACT_LU;
        else                            act = HZ_ACT_ADVANCE;
    end

    // Scan oldest to youngest so the youngest producer wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (slot_q[k].valid && slot_q[k].wen && !is_r0(slot_q[k].dest)
                && !(slot_q[k].load && k < LOAD_SLOT) && slot_q[0].valid) begin
                if (slot_q[0].rs_used && slot_q[k].dest == slot_q[0].rs) fwd_a = FW'(k);
                if (slot_q[0].rt_used && slot_q[k].dest == slot_q[0].rt) fwd_b = FW'(k);
            end
        end
    end

    hazard_slot_pipe #(.DEPTH(DEPTH)) u_slot_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .slot_i    (dec_slot),
        .hold0_i   (act == HZ_ACT_MC),
        .bubble0_i (act == HZ_ACT_FLUSH || act == HZ_ACT_LU),
        .bubble1_i (act == HZ_ACT_MC),
        .slots_o   (slot_q)
    );

    always_comb begin
        mc_cnt_d = mc_cnt_q;
        if (act == HZ_ACT_MC) begin
            mc_cnt_d = mc_cnt_q - MCW'(1);
        end else if (act == HZ_ACT_ADVANCE && hz.dec_valid && hz.dec_mc) begin
            mc_cnt_d = MCW'(MC_LAT - 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mc_cnt_q <= '0;
        end else begin
            mc_cnt_q <= mc_cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted, independent of slot state.
    assign hz.fetch_stall = !rst_i && (act == HZ_ACT_MC || act == HZ_ACT_LU);
    assign hz.dx_flush    = !rst_i && (act == HZ_ACT_FLUSH || act == HZ_ACT_LU);
    assign hz.ex_hold     = !rst_i && (act == HZ_ACT_MC);
    assign hz.mc_busy     = !rst_i && mc_busy;
    assign hz.fwd_a       = rst_i ? '0 : fwd_a;
    assign hz.fwd_b       = rst_i ? '0 : fwd_b;

`ifdef HAZARD_STATS_EN
    logic [31:0] lu_cnt_q;
    logic [31:0] mc_cnt_stat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lu_cnt_q      <= '0;
            mc_cnt_stat_q <= '0;
        end else begin
            if (act == HZ_ACT_LU && lu_cnt_q != '1)      lu_cnt_q      <= lu_cnt_q + 32'd1;
            if (act == HZ_ACT_MC && mc_cnt_stat_q != '1) mc_cnt_stat_q <= mc_cnt_stat_q + 32'd1;
        end
    end

    assign lu_stall_cnt_o = lu_cnt_q;
    assign mc_stall_cnt_o = mc_cnt_stat_q;
`endif

    a_no_flush_in_mc : assert property (@(posedge clk_i) disable iff (rst_i)
                                        !(hz.ex_br_flush && mc_busy));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle expected outputs are queued as
// each instruction is presented and compared mid-cycle.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int DEPTH     = 3;
    localparam int LOAD_SLOT = 2;
    localparam int MC_LAT    = 4;

    typedef struct {
        logic     rst;
        logic     valid;
        reg_idx_t rs;
        reg_idx_t rt;
        logic     rs_used;
        logic     rt_used;
        logic     wen;
        reg_idx_t dest;
        logic     load;
        logic     mc;
        logic     flush;
    } stim_t;

    typedef struct {
        int         id;
        logic       fs;
        logic       dx;
        logic       eh;
        logic       mb;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.DEPTH(DEPTH)) hz_if ();

`ifdef HAZARD_STATS_EN
    logic [31:0] lu_cnt;
    logic [31:0] mc_cnt;
`endif

    hazard_scoreboard #(
        .DEPTH     (DEPTH),
        .LOAD_SLOT (LOAD_SLOT),
        .MC_LAT    (MC_LAT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz_if)
`ifdef HAZARD_STATS_EN
        ,
        .lu_stall_cnt_o (lu_cnt),
        .mc_stall_cnt_o (mc_cnt)
`endif
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_id = 0;
    int   exp_lu  = 0;
    int   exp_mc  = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic stim_t nop();
        stim_t s = '{rst: 1'b0, valid: 1'b0, rs: '0, rt: '0, rs_used: 1'b0, rt_used: 1'b0,
                     wen: 1'b0, dest: '0, load: 1'b0, mc: 1'b0, flush: 1'b0};
        return s;
    endfunction

    function automatic stim_t alu(input int d, input int a, input int b);
        stim_t s = nop();
        s.valid = 1'b1; s.wen = 1'b1; s.dest = reg_idx_t'(d);
        s.rs = reg_idx_t'(a); s.rt = reg_idx_t'(b); s.rs_used = 1'b1; s.rt_used = 1'b1;
        return s;
    endfunction

    function automatic stim_t ld(input int d, input int a);
        stim_t s = nop();
        s.valid = 1'b1; s.wen = 1'b1; s.load = 1'b1; s.dest = reg_idx_t'(d);
        s.rs = reg_idx_t'(a); s.rs_used = 1'b1;
        return s;
    endfunction

    function automatic stim_t mul(input int d, input int a, input int b);
        stim_t s = alu(d, a, b);
        s.mc = 1'b1;
        return s;
    endfunction

    function automatic exp_t ex(input logic fs, input logic dx, input logic eh,
                                input logic mb, input int fa, input int fb);
        exp_t e = '{id: 0, fs: fs, dx: dx, eh: eh, mb: mb, fa: 2'(fa), fb: 2'(fb)};
        return e;
    endfunction

    // Drive one decode cycle, queue its expectation, then compare on the falling edge.
    task automatic step(input stim_t s, input exp_t e);
        exp_t q;
        rst                  = s.rst;
        hz_if.dec_valid      = s.valid;
        hz_if.dec_rs         = s.rs;
        hz_if.dec_rt         = s.rt;
        hz_if.dec_rs_used    = s.rs_used;
        hz_if.dec_rt_used    = s.rt_used;
        hz_if.dec_wen        = s.wen;
        hz_if.dec_dest       = s.dest;
        hz_if.dec_load       = s.load;
        hz_if.dec_mc         = s.mc;
        hz_if.ex_br_flush    = s.flush;
        e.id = step_id;
        exp_q.push_back(e);
        @(negedge clk);
        q = exp_q.pop_front();
        check($sformatf("s%0d.fetch_stall", q.id), 32'(hz_if.fetch_stall), 32'(q.fs));
        check($sformatf("s%0d.dx_flush", q.id),    32'(hz_if.dx_flush),    32'(q.dx));
        check($sformatf("s%0d.ex_hold", q.id),     32'(hz_if.ex_hold),     32'(q.eh));
        check($sformatf("s%0d.mc_busy", q.id),     32'(hz_if.mc_busy),     32'(q.mb));
        check($sformatf("s%0d.fwd_a", q.id),       32'(hz_if.fwd_a),       32'(q.fa));
        check($sformatf("s%0d.fwd_b", q.id),       32'(hz_if.fwd_b),       32'(q.fb));
        if (s.rst) begin
            exp_lu = 0;
            exp_mc = 0;
        end else begin
            if (q.fs && q.dx) exp_lu++;
            if (q.eh)         exp_mc++;
        end
        step_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats();
`ifdef HAZARD_STATS_EN
        check("lu_stall_cnt", lu_cnt, 32'(exp_lu));
        check("mc_stall_cnt", mc_cnt, 32'(exp_mc));
`endif
    endtask

    initial begin
        stim_t s;
        exp_t  z;
        z = ex(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset holding a valid load in decode: nothing may be captured.
        s = ld(5, 1); s.rst = 1'b1;
        step(s, z);
        step(s, z);
        step(nop(), z);
        step(alu(6, 5, 5), z);

        // ALU back-to-back forwarding from slot 1.
        step(alu(3, 1, 2), z);
        step(alu(4, 3, 3), z);
        step(nop(), ex(0, 0, 0, 0, 1, 1));
        step(nop(), z);

        // Load-use: one stall cycle, then forward from slot 2.
        step(ld(5, 1), z);
        step(alu(6, 5, 1), ex(1, 1, 0, 0, 0, 0));
        step(alu(6, 5, 1), z);
        step(nop(), ex(0, 0, 0, 0, 2, 0));

        // r0 destinations never stall or forward.
        step(alu(0, 1, 2), z);
        step(ld(0, 1), z);
        step(alu(1, 0, 0), z);
        step(nop(), z);

        // Multi-cycle op freezes EX for MC_LAT-1 cycles.
        step(mul(7, 1, 2), z);
        step(alu(8, 7, 7), ex(1, 0, 1, 1, 2, 0));
        step(alu(8, 7, 7), ex(1, 0, 1, 1, 0, 0));
        step(alu(8, 7, 7), ex(1, 0, 1, 1, 0, 0));
        step(alu(8, 7, 7), z);
        step(nop(), ex(0, 0, 0, 0, 1, 1));

        // Branch flush beats a simultaneous load-use.
        step(ld(9, 1), z);
        s = alu(10, 9, 9); s.flush = 1'b1;
        step(s, ex(0, 1, 0, 0, 0, 0));
        step(alu(10, 9, 9), z);
        step(nop(), ex(0, 0, 0, 0, 2, 2));

        // Unused source and invalid decode never stall.
        step(ld(11, 1), z);
        s = alu(12, 1, 11); s.rt_used = 1'b0;
        step(s, z);
        step(nop(), z);
        step(ld(13, 1), z);
        s = alu(14, 13, 13); s.valid = 1'b0;
        step(s, z);
        check_stats();

        // Reset in the middle of a multi-cycle op aborts it.
        step(mul(14, 3, 4), z);
        step(alu(15, 14, 3), ex(1, 0, 1, 1, 0, 0));
        s = alu(15, 14, 3); s.rst = 1'b1;
        step(s, z);
        step(nop(), z);
        check_stats();
        step(alu(15, 14, 3), z);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
